apb_cmd_queue: RTL and testbench

APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

---
 rtl/apb_pkg.sv | 38 +++
 rtl/apb_sync_fifo.sv | 53 +++++
 rtl/apb_cmd_queue.sv | 138 +++++++++++++
 tb/tb_apb_cmd_queue.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and architecture defaults for the APB command queue.
// The width macros may be supplied on the command line; otherwise the defaults below apply.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef STRB_SIZE
`define STRB_SIZE 2
`endif

package apb_pkg;

  localparam int unsigned AddrW        = `ADDR_WIDTH;
  localparam int unsigned DataW        = `DATA_WIDTH;
  localparam int unsigned StrbW        = `STRB_SIZE;
  localparam int unsigned DepthDefault = 4;

  localparam logic [StrbW-1:0] StrbByte = StrbW'(0);
  localparam logic [StrbW-1:0] StrbHalf = StrbW'(1);
  localparam logic [StrbW-1:0] StrbWord = StrbW'(2);

  typedef struct packed {
    logic             wr;
    logic [1:0]       dsel;
    logic [StrbW-1:0] strb;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/apb_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; read data is the current head, shown combinationally.
module apb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LvlW-1:0]  level
);

  localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  // Guard internally too, so a push at full can never overwrite the head.
  assign do_push = push && (level_q < Full);
  assign do_pop  = pop && (level_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  assign rdata = mem[rptr_q];
  assign level = level_q;

endmodule

// File: rtl/apb_cmd_queue.sv
// Queues CPU requests and feeds them one at a time to an APB master, returning one response each.
module apb_cmd_queue
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrW,
  parameter int unsigned DATA_WIDTH = DataW,
  parameter int unsigned STRB_SIZE  = StrbW,
  parameter int unsigned DEPTH      = DepthDefault,
  localparam int unsigned LvlW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_dsel,
  input  logic [STRB_SIZE-1:0]  req_strb,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  trnsfr,
  output logic                  wr,
  output logic [1:0]            dsel,
  output logic [STRB_SIZE-1:0]  strb,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  xfer_done,
  input  logic [DATA_WIDTH-1:0] xfer_rdata,
  input  logic                  xfer_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [LvlW-1:0]       level
);

  localparam int unsigned     ReqW = 1 + 2 + STRB_SIZE + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

  state_e state_q, state_d;
  logic   fifo_push, fifo_pop, capture_rsp;

  logic [ReqW-1:0] fifo_rdata;
  logic [LvlW-1:0] fifo_level;

  logic                  wr_q;
  logic [1:0]            dsel_q;
  logic [STRB_SIZE-1:0]  strb_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_wr_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  // Ready depends on occupancy only, so a pop never lets a same-cycle push in at full.
  assign req_ready = (fifo_level < Full);
  assign fifo_push = req_valid && req_ready;

  apb_sync_fifo #(
    .WIDTH(ReqW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata({req_wr, req_dsel, req_strb, req_addr, req_wdata}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .level(fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    capture_rsp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_level != '0) begin
          fifo_pop = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (xfer_done) begin
          capture_rsp = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (fifo_level != '0) begin
            fifo_pop = 1'b1;
            state_d  = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      dsel_q      <= '0;
      strb_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        {wr_q, dsel_q, strb_q, addr_q, wdata_q} <= fifo_rdata;
      end
      if (capture_rsp) begin
        rsp_wr_q    <= wr_q;
        rsp_rdata_q <= wr_q ? '0 : xfer_rdata;
        rsp_err_q   <= xfer_err;
      end
    end
  end

  assign trnsfr    = (state_q == StBusy);
  assign rsp_valid = (state_q == StResp);
  assign wr        = wr_q;
  assign dsel      = dsel_q;
  assign strb      = strb_q;
  assign address   = addr_q;
  assign data_in   = wdata_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign level     = fifo_level;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Bench for apb_cmd_queue: directed scenarios plus random traffic against a transaction-level model.
module tb_apb_cmd_queue;
  import apb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_wr;
  logic [1:0]       req_dsel;
  logic [StrbW-1:0] req_strb;
  logic [AddrW-1:0] req_addr;
  logic [DataW-1:0] req_wdata;
  logic             trnsfr, wr;
  logic [1:0]       dsel;
  logic [StrbW-1:0] strb;
  logic [AddrW-1:0] address;
  logic [DataW-1:0] data_in;
  logic             xfer_done, xfer_err;
  logic [DataW-1:0] xfer_rdata;
  logic             rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [DataW-1:0] rsp_rdata;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  apb_cmd_queue #(
    .ADDR_WIDTH(AddrW),
    .DATA_WIDTH(DataW),
    .STRB_SIZE (StrbW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_dsel  (req_dsel),
    .req_strb  (req_strb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .trnsfr    (trnsfr),
    .wr        (wr),
    .dsel      (dsel),
    .strb      (strb),
    .address   (address),
    .data_in   (data_in),
    .xfer_done (xfer_done),
    .xfer_rdata(xfer_rdata),
    .xfer_err  (xfer_err),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .level     (level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: pending queue, the request being transferred, and an outstanding response.
  req_t             mq[$];
  req_t             cur;
  bit               m_busy, m_pend;
  bit               e_wr, e_err;
  logic [DataW-1:0] e_rdata;

  // Called #1 after an edge with the next inputs already driven; advances one clock.
  task automatic tick();
    bit               p_rst, p_push, p_busy, p_done, p_pend, p_rr, p_err, exp_trn;
    int               p_lvl;
    req_t             p_req;
    logic [DataW-1:0] p_rdata;
    p_rst   = rst;
    p_lvl   = mq.size();
    p_push  = req_valid && (p_lvl < DEPTH);
    p_busy  = m_busy;
    p_done  = xfer_done;
    p_pend  = m_pend;
    p_rr    = rsp_ready;
    p_rdata = xfer_rdata;
    p_err   = xfer_err;
    p_req.wr    = req_wr;
    p_req.dsel  = req_dsel;
    p_req.strb  = req_strb;
    p_req.addr  = req_addr;
    p_req.wdata = req_wdata;
    if (!p_rst) check_eq("req_ready", req_ready, p_lvl < DEPTH);
    @(posedge clk);
    #1;
    if (p_rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_pend = 1'b0;
      check_eq("reset_outputs", {trnsfr, rsp_valid, level, wr, dsel, strb, address, data_in,
                                 rsp_wr, rsp_rdata, rsp_err}, '0);
      return;
    end
    exp_trn = p_busy ? !p_done : (p_lvl > 0 && (!p_pend || p_rr));
    if (p_push) mq.push_back(p_req);
    if (exp_trn && !p_busy) cur = mq.pop_front();
    m_busy = exp_trn;
    check_eq("trnsfr", trnsfr, exp_trn);
    if (exp_trn) check_eq("apb_outputs", {wr, dsel, strb, address, data_in}, cur);
    if (p_busy && p_done) begin
      m_pend  = 1'b1;
      e_wr    = cur.wr;
      e_rdata = cur.wr ? '0 : p_rdata;
      e_err   = p_err;
    end else if (p_pend && p_rr) begin
      m_pend = 1'b0;
    end
    check_eq("rsp_valid", rsp_valid, m_pend);
    if (m_pend) check_eq("rsp_fields", {rsp_wr, rsp_rdata, rsp_err}, {e_wr, e_rdata, e_err});
    check_eq("level", level, mq.size());
  endtask

  task automatic set_req(input bit w, input logic [1:0] d, input logic [StrbW-1:0] s,
                         input logic [AddrW-1:0] a, input logic [DataW-1:0] dt);
    req_valid = 1'b1;
    req_wr    = w;
    req_dsel  = d;
    req_strb  = s;
    req_addr  = a;
    req_wdata = dt;
  endtask

  task automatic drain();
    int budget = 400;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((mq.size() != 0 || m_busy || m_pend) && budget > 0) begin
      xfer_done  = trnsfr;
      xfer_rdata = $urandom;
      xfer_err   = ($urandom_range(0, 3) == 0);
      tick();
      budget--;
    end
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    rsp_ready = 1'b0;
    check_eq("drained", {trnsfr, rsp_valid, level}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_dsel = '0; req_strb = '0;
    req_addr = '0; req_wdata = '0; xfer_done = 1'b0; xfer_rdata = '0; xfer_err = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_ready", req_ready, 1'b1);

    // Single write: two-cycle latency and zeroed read data on the response.
    set_req(1'b1, 2'd1, StrbWord, 32'h10, 32'hDEADBEEF);
    tick();
    req_valid = 1'b0;
    check_eq("s1_cycle1_trnsfr", {trnsfr, level}, {1'b0, 3'd1});
    tick();
    check_eq("s1_cycle2_outputs", {trnsfr, wr, dsel, strb, address, data_in},
             {1'b1, 1'b1, 2'd1, StrbWord, 32'h10, 32'hDEADBEEF});
    xfer_rdata = 32'hFFFF0000;
    xfer_done  = 1'b1;
    tick();
    xfer_done = 1'b0;
    check_eq("s1_rsp", {rsp_valid, rsp_wr, rsp_rdata, rsp_err}, {1'b1, 1'b1, 32'h0, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("s1_back_to_idle", {trnsfr, rsp_valid}, 2'b00);

    // Fill the queue: five pushes leave one in flight and four queued.
    for (int i = 0; i < 5; i++) begin
      set_req(i[0], i[1:0], StrbWord, 32'h100 + 32'(i) * 4, $urandom);
      tick();
    end
    check_eq("s2_full_level", level, 4);
    check_eq("s2_full_ready", req_ready, 1'b0);
    set_req(1'b1, 2'd3, StrbHalf, 32'h200, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s2_stall_level", level, 4);
    end
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("s2_after_pop", level, 3);
    tick();
    req_valid = 1'b0;
    check_eq("s2_sixth_accepted", level, 4);
    drain();

    // Read with slave error, followed by a queued write that must still issue.
    set_req(1'b0, 2'd2, StrbWord, 32'h20, 32'h0);
    tick();
    set_req(1'b1, 2'd3, StrbByte, 32'h24, 32'h55);
    tick();
    req_valid = 1'b0;
    check_eq("s3_read_issue", {trnsfr, wr, address}, {1'b1, 1'b0, 32'h20});
    xfer_rdata = 32'h12345678;
    xfer_err   = 1'b1;
    xfer_done  = 1'b1;
    tick();
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    check_eq("s3_err_rsp", {rsp_valid, rsp_wr, rsp_rdata, rsp_err},
             {1'b1, 1'b0, 32'h12345678, 1'b1});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("s3_next_issue", {trnsfr, address}, {1'b1, 32'h24});

    // Response back-pressure with a request waiting behind it.
    set_req(1'b0, 2'd0, StrbHalf, 32'h28, 32'h0);
    tick();
    req_valid = 1'b0;
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s4_hold", {trnsfr, rsp_valid, rsp_wr, rsp_rdata, rsp_err, level},
               {1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 3'd1});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("s4_direct_busy", {trnsfr, rsp_valid, address}, {1'b1, 1'b0, 32'h28});
    drain();

    // Stray completion while idle.
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check_eq("s5_stray_done", rsp_valid, 1'b0);
    tick();
    check_eq("s5_stray_done_later", rsp_valid, 1'b0);

    // Reset while busy with three requests queued.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'd1, StrbWord, 32'h300 + 32'(i) * 4, $urandom);
      tick();
    end
    req_valid = 1'b0;
    check_eq("s6_before_reset", {trnsfr, level}, {1'b1, 3'd3});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s6_after_reset", {trnsfr, level}, '0);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    check_eq("s6_no_rsp", {rsp_valid, trnsfr}, 2'b00);
    tick();
    check_eq("s6_still_idle", {rsp_valid, trnsfr, level}, '0);

    // Random traffic, including stray completions and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      req_wr     = 1'($urandom);
      req_dsel   = 2'($urandom);
      req_strb   = StrbW'($urandom_range(0, 2));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      xfer_done  = ($urandom_range(0, 3) == 0);
      xfer_rdata = $urandom;
      xfer_err   = ($urandom_range(0, 4) == 0);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
